// File: rtl/knn_vote_if.sv
// Handshake bundle between the k-NN vote block, the distance sorter and the label memory.
// The slave side is the vote block; the master side is the sorter/memory/requester.
interface knn_vote_if #(
  parameter int W  = 32,
  parameter int LW = 4
);
  logic              start;
  logic [1:0]        sel;
  logic [W/4-1:0]    idx;
  logic [W/4-1:0]    lbl_addr;
  logic              lbl_rd;
  logic [LW-1:0]     lbl_data;
  logic              busy;
  logic              valid;
  logic [LW-1:0]     label;
  logic [2:0]        votes;

  modport slave (
    input  start, idx, lbl_data,
    output sel, lbl_addr, lbl_rd, busy, valid, label, votes
  );

  modport master (
    output start, idx, lbl_data,
    input  sel, lbl_addr, lbl_rd, busy, valid, label, votes
  );
endinterface

// File: rtl/knn_vote.sv
// Majority vote over the K=4 nearest neighbours' class labels, fetched rank by rank
// from the sorter and label memory; incremental winner tracking, first-to-reach wins ties.
module knn_vote #(
  parameter int W  = 32,
  parameter int LW = 4,
  parameter int K  = 4
) (
  input  logic       clk,
  input  logic       rst,
  knn_vote_if.slave  bus
);
  localparam int IW = W / 4;
  localparam int NL = 2 ** LW;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [1:0]      sel_p0;
  logic            rd_c;
  logic            busy_c;
  logic            accept;
  logic            vld_p1;
  logic [2:0]      cnt [NL];
  logic [2:0]      cnt_new;
  logic [2:0]      best_count;
  logic [LW-1:0]   label_q;
  logic [2:0]      votes_q;
  logic            valid_q;
  logic [IW-1:0]   idx_c;

  function automatic logic [2:0] vote_inc(input logic [2:0] c);
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

  assign idx_c        = bus.idx;
  assign bus.lbl_addr = idx_c;
  assign bus.lbl_rd   = rd_c;
  assign bus.busy     = busy_c;
  assign bus.sel      = sel_p0;
  assign bus.valid    = valid_q;
  assign bus.label    = label_q;
  assign bus.votes    = votes_q;

  assign accept  = (state == IDLE) && bus.start;
  assign cnt_new = vote_inc(cnt[bus.lbl_data]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_c      = 1'b0;
    busy_c    = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = FETCH;
      FETCH: begin
        rd_c   = 1'b1;
        busy_c = 1'b1;
        if (sel_p0 == 2'(K - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: rank select toward the sorter, one rank per FETCH cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  sel_p0 <= '0;
    else if (state != FETCH)  sel_p0 <= '0;
    else if (sel_p0 == 2'(K - 1)) sel_p0 <= '0;
    else                      sel_p0 <= sel_p0 + 2'd1;
  end

  // Stage p1: label memory returns data one cycle after the read was sampled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) cnt[i] <= '0;
      best_count <= '0;
      label_q    <= '0;
      votes_q    <= '0;
      valid_q    <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < NL; i++) cnt[i] <= '0;
      best_count <= '0;
      label_q    <= '0;
      votes_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (vld_p1) begin
        cnt[bus.lbl_data] <= cnt_new;
        // Strict greater-than keeps the label that reached a tied count first
        if (cnt_new > best_count) begin
          best_count <= cnt_new;
          votes_q    <= cnt_new;
          label_q    <= bus.lbl_data;
        end
      end
      if (state == DRAIN) valid_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_knn_vote.sv
// Randomized and directed checks of knn_vote against a count-based voting model,
// with a sorter stub (idx from sel) and a one-cycle-latency label memory.
module tb_knn_vote;
  localparam int W  = 32;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] nbr_idx [4];
  logic [3:0] mem [256];

  knn_vote_if #(.W(W), .LW(LW)) bus ();

  knn_vote #(.W(W), .LW(LW), .K(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb bus.idx = nbr_idx[bus.sel];

  always @(posedge clk) if (bus.lbl_rd) bus.lbl_data <= mem[bus.lbl_addr];

  // Winner = label with the highest final count; among ties, the one whose
  // m-th occurrence comes earliest in rank order.
  function automatic void ref_vote(input logic [15:0] labs, output logic [3:0] lab, output int v);
    int c [16];
    int run [16];
    int m;
    logic [3:0] l;
    for (int i = 0; i < 16; i++) begin c[i] = 0; run[i] = 0; end
    for (int i = 0; i < 4; i++) c[labs[4*i +: 4]]++;
    m = 0;
    for (int i = 0; i < 16; i++) if (c[i] > m) m = c[i];
    lab = '0;
    for (int i = 0; i < 4; i++) begin
      l = labs[4*i +: 4];
      run[l]++;
      if (run[l] == m) begin lab = l; break; end
    end
    v = m;
  endfunction

  task automatic do_run(input logic [15:0] labs, input bit extra_start,
                        output int lat, output int busy_cyc, output int rd_cyc,
                        output bit sel_ok, output logic valid0);
    logic [7:0] base;
    int n;
    @(negedge clk);
    base = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      nbr_idx[i] = base + 8'(37 * i);
      mem[nbr_idx[i]] = labs[4*i +: 4];
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1; busy_cyc = 0; rd_cyc = 0; sel_ok = 1'b1; valid0 = 1'bx;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (n == 0) valid0 = bus.valid;
      if (bus.valid === 1'b1) begin lat = n; break; end
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.lbl_rd === 1'b1) begin
        if (bus.sel !== 2'(rd_cyc)) sel_ok = 1'b0;
        rd_cyc++;
      end
      if (extra_start && n == 1) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] rl; int rv, lat, bc, rc; bit so; logic v0;
    n_checks++; if ({bus.busy, bus.valid, bus.lbl_rd} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got %b want 000", {bus.busy, bus.valid, bus.lbl_rd}); end
    n_checks++; if ({bus.sel, bus.label, bus.votes} !== 9'd0) begin n_fail++; $display("FAIL reset_data got sel=%0d label=%0d votes=%0d want 0", bus.sel, bus.label, bus.votes); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got busy=%b valid=%b want 0 0", bus.busy, bus.valid); end
    // A finished result must be wiped by reset without a clock edge
    do_run(16'h7777, 1'b0, lat, bc, rc, so, v0);
    ref_vote(16'h7777, rl, rv);
    n_checks++; if (bus.label !== rl || bus.votes !== 3'(rv)) begin n_fail++; $display("FAIL pre_reset_result got %0d/%0d want %0d/%0d", bus.label, bus.votes, rl, rv); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({bus.valid, bus.label, bus.votes} !== 8'd0) begin n_fail++; $display("FAIL async_reset_result got valid=%b label=%0d votes=%0d want 0", bus.valid, bus.label, bus.votes); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unanimous();
    int lat, bc, rc; bit so; logic v0;
    do_run(16'h5555, 1'b0, lat, bc, rc, so, v0);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL unan_latency got %0d want 5", lat); end
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL unan_busy_cycles got %0d want 5", bc); end
    n_checks++; if (rc !== 4 || !so) begin n_fail++; $display("FAIL unan_rd_sel got rd=%0d sel_ok=%0d want 4 1", rc, so); end
    n_checks++; if (bus.label !== 4'd5 || bus.votes !== 3'd4) begin n_fail++; $display("FAIL unan_result got %0d/%0d want 5/4", bus.label, bus.votes); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL unan_busy_with_valid got %b want 0", bus.busy); end
  endtask

  task automatic test_tie_and_distinct();
    int lat, bc, rc; bit so; logic v0;
    // nearest first occupies the low nibble
    do_run(16'h2772, 1'b0, lat, bc, rc, so, v0);
    n_checks++; if (bus.label !== 4'd7 || bus.votes !== 3'd2) begin n_fail++; $display("FAIL tie_result got %0d/%0d want 7/2", bus.label, bus.votes); end
    do_run(16'h4321, 1'b0, lat, bc, rc, so, v0);
    n_checks++; if (bus.label !== 4'd1 || bus.votes !== 3'd1) begin n_fail++; $display("FAIL distinct_result got %0d/%0d want 1/1", bus.label, bus.votes); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL distinct_latency got %0d want 5", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, rc; bit so; logic v0; logic [3:0] l2; logic [2:0] v2;
    do_run(16'h1999, 1'b0, lat, bc, rc, so, v0);
    n_checks++; if (bus.label !== 4'd9 || bus.votes !== 3'd3) begin n_fail++; $display("FAIL b2b_run1 got %0d/%0d want 9/3", bus.label, bus.votes); end
    do_run(16'h9933, 1'b1, lat, bc, rc, so, v0);
    n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop got %b want 0", v0); end
    n_checks++; if (lat !== 5 || bc !== 5 || rc !== 4) begin n_fail++; $display("FAIL b2b_timing got lat=%0d busy=%0d rd=%0d want 5 5 4", lat, bc, rc); end
    n_checks++; if (bus.label !== 4'd3 || bus.votes !== 3'd2) begin n_fail++; $display("FAIL b2b_run2 got %0d/%0d want 3/2", bus.label, bus.votes); end
    l2 = bus.label; v2 = bus.votes;
    repeat (4) @(negedge clk);
    n_checks++; if (bus.valid !== 1'b1 || bus.busy !== 1'b0 || bus.label !== 4'd3 || bus.votes !== 3'd2) begin n_fail++; $display("FAIL b2b_hold got valid=%b busy=%b %0d/%0d want 1 0 %0d/%0d", bus.valid, bus.busy, bus.label, bus.votes, l2, v2); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, rc; bit so; logic v0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin nbr_idx[i] = 8'(10 + i); mem[nbr_idx[i]] = 4'd6; end
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_checks++; if ({bus.busy, bus.lbl_rd, bus.valid, bus.sel} !== 5'd0) begin n_fail++; $display("FAIL mid_reset_async got busy=%b rd=%b valid=%b sel=%0d want 0", bus.busy, bus.lbl_rd, bus.valid, bus.sel); end
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.lbl_rd !== 1'b0) begin n_fail++; $display("FAIL no_resume got busy=%b valid=%b rd=%b want 0 0 0", bus.busy, bus.valid, bus.lbl_rd); end
    do_run(16'h0066, 1'b0, lat, bc, rc, so, v0);
    n_checks++; if (bus.label !== 4'd6 || bus.votes !== 3'd2 || lat !== 5) begin n_fail++; $display("FAIL fresh_run got %0d/%0d lat=%0d want 6/2 lat=5", bus.label, bus.votes, lat); end
  endtask

  task automatic test_random();
    logic [15:0] labs; logic [3:0] rl; int rv, lat, bc, rc; bit so; logic v0;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 4; i++)
        labs[4*i +: 4] = (t % 2 == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      ref_vote(labs, rl, rv);
      do_run(labs, (t % 3 == 0), lat, bc, rc, so, v0);
      n_checks++; if (bus.label !== rl || bus.votes !== 3'(rv) || lat !== 5 || !so) begin n_fail++; $display("FAIL rand_%0d labs=%h got %0d/%0d lat=%0d sel_ok=%0d want %0d/%0d lat=5 sel_ok=1", t, labs, bus.label, bus.votes, lat, so, rl, rv); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) nbr_idx[i] = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_unanimous();
    test_tie_and_distinct();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
